// File: rtl/mips_hilo_muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   - op_func_t / op_source_e : decoded opFunc word (source bit + 6-bit code)
//   - FUNC_* constants        : the eight HI/LO function codes
//   - hilo_state_e            : sequencer FSM state encoding
//   - is_hilo_op()            : true for any of the eight HI/LO instructions
package mips_hilo_muldiv_sequencer_pkg;

  typedef enum logic {
    SOURCE_OP   = 1'b0,
    SOURCE_FUNC = 1'b1
  } op_source_e;

  typedef struct packed {
    op_source_e  source;
    logic [5:0]  code;
  } op_func_t;

  localparam logic [5:0] FUNC_MFHI  = 6'h10;
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MFLO  = 6'h12;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } hilo_state_e;

  function automatic logic is_hilo_op(input op_func_t f);
    return (f.source == SOURCE_FUNC) &&
           (f.code inside {FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO,
                           FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU});
  endfunction

endpackage

// File: rtl/mips_hilo_muldiv_datapath.sv
// Iterative multiply/divide datapath.
// Holds a 2*WIDTH accumulator and a WIDTH-bit operand register, one shared
// WIDTH+1-bit adder/subtractor, and the sign-correction negators.
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_load_mul / i_load_div : latch operand magnitudes (i_signed selects abs)
//   i_div_zero              : divisor is zero; preload {rs, all-ones} instead
//   i_step_mul / i_step_div : one shift-add / one restoring-division step
//   i_is_div                : result select (hi=remainder, lo=quotient)
//   i_neg_main / i_neg_rem  : negate product-or-quotient / remainder
//   i_rs, i_rt              : raw operands
//   o_res_hi, o_res_lo      : sign-corrected result, written by the caller
module mips_hilo_muldiv_datapath #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load_mul,
  input  logic             i_load_div,
  input  logic             i_div_zero,
  input  logic             i_signed,
  input  logic             i_step_mul,
  input  logic             i_step_div,
  input  logic             i_is_div,
  input  logic             i_neg_main,
  input  logic             i_neg_rem,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [WIDTH-1:0] o_res_lo
);

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  // Divide:   r_acc = {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;

  logic [WIDTH-1:0]   w_rs_mag, w_rt_mag;
  logic [WIDTH:0]     w_add_a, w_add_b, w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;

  // The most-negative value negates to itself, which is its correct
  // unsigned magnitude.
  assign w_rs_mag = (i_signed && i_rs[WIDTH-1]) ? -i_rs : i_rs;
  assign w_rt_mag = (i_signed && i_rt[WIDTH-1]) ? -i_rt : i_rt;

  // Divide feeds the remainder shifted left with the next dividend bit.
  assign w_add_a = i_step_div ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_add_b = {1'b0, r_opnd};
  assign w_sum   = i_step_div ? (w_add_a - w_add_b) : (w_add_a + w_add_b);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (i_load_mul) begin
      r_opnd <= w_rs_mag;
      r_acc  <= {{WIDTH{1'b0}}, w_rt_mag};
    end else if (i_load_div) begin
      if (i_div_zero) begin
        r_opnd <= '0;
        r_acc  <= {i_rs, {WIDTH{1'b1}}};
      end else begin
        r_opnd <= w_rt_mag;
        r_acc  <= {{WIDTH{1'b0}}, w_rs_mag};
      end
    end else if (i_step_mul) begin
      r_acc <= r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    end else if (i_step_div) begin
      // Bit WIDTH of the difference is set exactly when the trial subtract borrowed.
      r_acc <= (!w_sum[WIDTH]) ? {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                               : {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    w_prod = i_neg_main ? -r_acc : r_acc;
    w_quo  = i_neg_main ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem  = i_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    o_res_hi = i_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    o_res_lo = i_is_div ? w_quo : w_prod[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_hilo_muldiv_sequencer.sv
// HI/LO register pair and multiply/divide sequencer for the EX stage.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_issue          : valid instruction in EX this cycle
//   i_op_func        : decoded opFunc word
//   i_rs, i_rt       : operands (dividend/multiplicand/MT data, divisor/multiplier)
//   o_stall          : hold IF/ID/EX this cycle
//   o_busy           : multiply/divide in flight
//   o_hi, o_lo       : HI and LO registers
//   o_dbg_state      : current FSM state
// Handshake: a HI/LO instruction is taken in any cycle where i_issue=1 and
// o_stall=0; while o_stall=1 the stage must hold i_op_func/i_rs/i_rt stable
// and re-present them. Non-HI/LO instructions never stall.
module mips_hilo_muldiv_sequencer
  import mips_hilo_muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_issue,
  input  op_func_t         i_op_func,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic             o_stall,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output hilo_state_e      o_dbg_state
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  hilo_state_e      r_state, w_state_next;
  logic [CW-1:0]    r_count;
  logic             r_neg_main, r_neg_rem, r_is_div;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_is_hilo, w_accept, w_signed, w_div_zero;
  logic             w_load_mul, w_load_div, w_step_mul, w_step_div, w_fixup;
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic [5:0]       w_code;

  assign w_code     = i_op_func.code;
  assign w_is_hilo  = is_hilo_op(i_op_func);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_stall    = i_issue & w_is_hilo & o_busy;
  assign w_accept   = i_issue & w_is_hilo & ~o_busy;
  assign w_signed   = (w_code == FUNC_MULT) || (w_code == FUNC_DIV);
  assign w_div_zero = (i_rt == '0);

  assign o_hi        = r_hi;
  assign o_lo        = r_lo;
  assign o_dbg_state = r_state;

  always_comb begin
    w_state_next = r_state;
    w_load_mul   = 1'b0;
    w_load_div   = 1'b0;
    w_step_mul   = 1'b0;
    w_step_div   = 1'b0;
    w_fixup      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_code == FUNC_MULT || w_code == FUNC_MULTU) begin
            w_load_mul   = 1'b1;
            w_state_next = ST_MUL;
          end else if (w_code == FUNC_DIV || w_code == FUNC_DIVU) begin
            w_load_div   = 1'b1;
            // Divide-by-zero result is preloaded; skip the iterations.
            w_state_next = w_div_zero ? ST_FIXUP : ST_DIV;
          end
        end
      end
      ST_MUL: begin
        w_step_mul = 1'b1;
        if (r_count == CW'(1)) w_state_next = ST_FIXUP;
      end
      ST_DIV: begin
        w_step_div = 1'b1;
        if (r_count == CW'(1)) w_state_next = ST_FIXUP;
      end
      ST_FIXUP: begin
        w_fixup      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count    <= '0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_is_div   <= 1'b0;
    end else if (w_load_mul) begin
      r_count    <= CW'(WIDTH);
      r_neg_main <= w_signed & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
      r_neg_rem  <= 1'b0;
      r_is_div   <= 1'b0;
    end else if (w_load_div) begin
      r_count    <= CW'(WIDTH);
      r_neg_main <= w_signed & ~w_div_zero & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
      r_neg_rem  <= w_signed & ~w_div_zero & i_rs[WIDTH-1];
      r_is_div   <= 1'b1;
    end else if (w_step_mul || w_step_div) begin
      r_count <= r_count - CW'(1);
    end else if (w_fixup) begin
      r_count <= '0;
    end
  end

  // HI/LO only move on FIXUP or an accepted MTHI/MTLO; the two cannot
  // coincide because MTHI/MTLO are stalled until IDLE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fixup) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (w_accept && w_code == FUNC_MTHI) begin
      r_hi <= i_rs;
    end else if (w_accept && w_code == FUNC_MTLO) begin
      r_lo <= i_rs;
    end
  end

  mips_hilo_muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .i_clk      (i_clock),
    .i_reset    (i_reset),
    .i_load_mul (w_load_mul),
    .i_load_div (w_load_div),
    .i_div_zero (w_div_zero),
    .i_signed   (w_signed),
    .i_step_mul (w_step_mul),
    .i_step_div (w_step_div),
    .i_is_div   (r_is_div),
    .i_neg_main (r_neg_main),
    .i_neg_rem  (r_neg_rem),
    .i_rs       (i_rs),
    .i_rt       (i_rt),
    .o_res_hi   (w_res_hi),
    .o_res_lo   (w_res_lo)
  );

endmodule

// File: tb/tb_mips_hilo_muldiv_sequencer.sv
module tb_mips_hilo_muldiv_sequencer;
  import mips_hilo_muldiv_sequencer_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         issue;
  op_func_t     op;
  logic [W-1:0] rs, rt;
  logic         stall, busy;
  logic [W-1:0] hi, lo;
  hilo_state_e  dbg_state;

  always #5 clk = ~clk;

  mips_hilo_muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_issue     (issue),
    .i_op_func   (op),
    .i_rs        (rs),
    .i_rt        (rt),
    .o_stall     (stall),
    .o_busy      (busy),
    .o_hi        (hi),
    .o_lo        (lo),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] m_hi, m_lo;   // reference HI/LO

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: plain 64-bit arithmetic over the architectural rules.
  task automatic model_apply(input logic [5:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    case (code)
      FUNC_MTHI: m_hi = a;
      FUNC_MTLO: m_lo = a;
      FUNC_MULT: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      FUNC_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      FUNC_DIV: begin
        if (b == '0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q  = sa / sb;
          r  = sa % sb;
          m_lo = q[31:0];
          m_hi = r[31:0];
        end
      end
      FUNC_DIVU: begin
        if (b == '0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Presents one instruction until taken; returns the number of stalled cycles.
  task automatic do_op(input bit func_src, input logic [5:0] code,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       output int stall_cycles);
    bit accepted;
    op.source = func_src ? SOURCE_FUNC : SOURCE_OP;
    op.code   = code;
    rs        = a;
    rt        = b;
    if (func_src && code == FUNC_MFHI) begin
      exp_q.push_back(m_hi);
      name_q.push_back("mfhi_read");
    end else if (func_src && code == FUNC_MFLO) begin
      exp_q.push_back(m_lo);
      name_q.push_back("mflo_read");
    end
    issue        = 1'b1;
    stall_cycles = 0;
    accepted     = 1'b0;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      if (stall) stall_cycles++;
      else       accepted = 1'b1;
    end
    if (!accepted) timeout_fail("accept_wait");
    @(posedge clk);
    if (func_src) model_apply(code, a, b);
    #1;
    issue = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (busy) n++;
      else      done = 1'b1;
    end
    if (!done) timeout_fail("busy_wait");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  // An MFHI/MFLO is taken in any cycle it is issued without stall; the EX
  // stage reads HI/LO in that cycle.
  always @(negedge clk) begin
    if (!rst && issue && op.source == SOURCE_FUNC &&
        (op.code == FUNC_MFHI || op.code == FUNC_MFLO) && !stall) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h expected none", (op.code == FUNC_MFHI) ? hi : lo);
      end else begin
        check(name_q.pop_front(), (op.code == FUNC_MFHI) ? hi : lo, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [5:0] codes[8];
  int         sc, nb;

  initial begin
    codes = '{FUNC_MFHI, FUNC_MTHI, FUNC_MFLO, FUNC_MTLO,
              FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
    rst   = 1'b1;
    issue = 1'b0;
    op    = '{source: SOURCE_OP, code: 6'h0};
    rs    = '0;
    rt    = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", W'(busy), 32'd0);
    check("reset_stall", W'(stall), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // MULTU all-ones squared
    do_op(1, FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc);
    measure_busy(nb);
    check("multu_busy_cycles", W'(nb), 32'd33);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    idle(1);
    do_op(1, FUNC_MFHI, 0, 0, sc);
    do_op(1, FUNC_MFLO, 0, 0, sc);

    // MULT -7*3 with an MFLO right behind it
    do_op(1, FUNC_MULT, 32'hFFFF_FFF9, 32'd3, sc);
    do_op(1, FUNC_MFLO, 0, 0, sc);
    check("mflo_stall_cycles", W'(sc), 32'd33);
    @(negedge clk);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    @(posedge clk);
    #1;

    // DIV -7/2; HI/LO must hold old values while in flight
    do_op(1, FUNC_DIV, 32'hFFFF_FFF9, 32'd2, sc);
    idle(5);
    @(negedge clk);
    check("hold_hi", hi, 32'hFFFF_FFFF);
    check("hold_lo", lo, 32'hFFFF_FFEB);
    measure_busy(nb);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    idle(1);
    do_op(1, FUNC_DIVU, 32'd100, 32'd7, sc);
    do_op(1, FUNC_MFLO, 0, 0, sc);
    do_op(1, FUNC_MFHI, 0, 0, sc);
    @(negedge clk);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    @(posedge clk);
    #1;

    // Divide by zero
    do_op(1, FUNC_DIV, 32'h1234_5678, 32'd0, sc);
    measure_busy(nb);
    check("divzero_busy_cycles", W'(nb), 32'd1);
    check("divzero_lo", lo, 32'hFFFF_FFFF);
    check("divzero_hi", hi, 32'h1234_5678);
    idle(1);

    // MTHI/MTLO back to back
    do_op(1, FUNC_MTHI, 32'h0000_DEAD, 0, sc);
    check("mthi_stall", W'(sc), 32'd0);
    do_op(1, FUNC_MTLO, 32'h0000_BEEF, 0, sc);
    check("mtlo_stall", W'(sc), 32'd0);
    @(negedge clk);
    check("mthi_value", hi, 32'h0000_DEAD);
    check("mtlo_value", lo, 32'h0000_BEEF);
    @(posedge clk);
    #1;

    // Unrelated instructions during a MULT never stall
    do_op(1, FUNC_MULT, 32'h8000_0000, 32'hFFFF_FFFF, sc);
    do_op(0, 6'h20, 32'd1, 32'd2, sc);
    check("add_op_stall", W'(sc), 32'd0);
    do_op(0, FUNC_MFHI, 32'd1, 32'd2, sc);
    check("op_src_0x10_stall", W'(sc), 32'd0);
    do_op(1, 6'h20, 32'd1, 32'd2, sc);
    check("func_add_stall", W'(sc), 32'd0);
    do_op(1, FUNC_MFHI, 0, 0, sc);
    do_op(1, FUNC_MFLO, 0, 0, sc);

    // Reset in the middle of a MULT
    do_op(1, FUNC_MULT, 32'h0001_2345, 32'h0006_789A, sc);
    idle(9);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", W'(busy), 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    check("midreset_stall", W'(stall), 32'd0);
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_op(1, FUNC_MULTU, 32'd3, 32'd5, sc);
    do_op(1, FUNC_MFLO, 0, 0, sc);
    @(negedge clk);
    check("after_reset_multu_lo", lo, 32'd15);
    @(posedge clk);
    #1;

    // Random instruction stream against the reference model
    for (int i = 0; i < 60; i++) begin
      do_op(1, codes[$urandom_range(0, 7)], rand_val(), rand_val(), sc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    do_op(1, FUNC_MFHI, 0, 0, sc);
    do_op(1, FUNC_MFLO, 0, 0, sc);

    idle(3);
    check("queue_drained", W'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_hilo_muldiv_sequencer.md
# mips_hilo_muldiv_sequencer

Sequencer for the HI/LO register pair and the iterative multiply/divide unit in the EX stage of the pipelined MIPS core. Consumes the decoded opFunc word from instruction decode together with the rs/rt operand values, runs MULT/MULTU/DIV/DIVU as a multi-cycle shift/add or shift/subtract sequence, services MTHI/MTLO/MFHI/MFLO, and raises a pipeline stall whenever a HI/LO instruction arrives while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- issue  input  1  valid instruction in EX this cycle
- opFunc  input  OpFunc_T (source bit + 6-bit code)  decoded opFunc; only Source_Func codes act here
- rs  input  WIDTH  first operand; dividend, multiplicand, or MTHI/MTLO data
- rt  input  WIDTH  second operand; divisor, multiplier
- stall  output  1  hold IF/ID/EX this cycle
- busy  output  1  multiply/divide in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- Recognised Source_Func codes: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other opFunc, or any Source_Op value, is ignored and never stalls.
- A HI/LO instruction is accepted when issue=1 and stall=0.
- FSM states: IDLE, MUL, DIV, FIXUP.
- IDLE + accepted MULT/MULTU: latch operand magnitudes (MULTU: raw values; MULT: absolute values plus result-sign flag rs[WIDTH-1]^rt[WIDTH-1]), clear the 2*WIDTH accumulator, load counter with WIDTH, go to MUL.
- IDLE + accepted DIV/DIVU: latch magnitudes, quotient-sign and remainder-sign (= dividend sign) flags, go to DIV. If rt==0: go straight to FIXUP with lo = all ones, hi = rs, and no sign correction.
- MUL: one shift-add per cycle on the multiplier LSB; counter decrements; at counter 1 go to FIXUP.
- DIV: one restoring-division step per cycle (shift remainder left, trial-subtract divisor, set quotient bit on no borrow); at counter 1 go to FIXUP.
- FIXUP: apply two's-complement negation where flagged (product full 2*WIDTH; quotient and remainder separately); write {hi,lo} = product or hi = remainder, lo = quotient; go to IDLE.
- MTHI/MTLO accepted in IDLE: hi (or lo) <= rs at the next edge.
- MFHI/MFLO: no state change; the EX stage reads hi/lo combinationally in the accepting cycle.
- busy = (state != IDLE).
- stall = issue & (opFunc is any of the eight codes) & busy. This covers reads, writes, and a new MULT/DIV during an operation.
- Arithmetic: magnitudes are WIDTH bits unsigned. The most-negative value is negated to itself and is correct as unsigned. Signed DIV of most-negative by -1 yields lo = most-negative, hi = 0.

## Timing
- Reset: state IDLE, counter 0, hi = 0, lo = 0, busy = 0, stall = 0. Reset mid-operation aborts the operation; HI/LO are cleared and no partial result is written.
- Latency for MULT/DIV accepted at edge N: busy is high for cycles N+1 .. N+WIDTH+1, and hi/lo are valid from cycle N+WIDTH+2 (34 cycles for WIDTH=32).
- Divide-by-zero: busy only for cycle N+1; hi/lo are valid at N+2.
- hi/lo change only on the FIXUP edge or an MTHI/MTLO edge. They hold their old values throughout MUL/DIV.
- stall is combinational from issue/opFunc/state; there is no registered delay. The cycle in which busy drops is the cycle a stalled MFHI/MFLO is accepted and reads the new value.
- An MTHI and a completing FIXUP cannot collide, because the MTHI is stalled until IDLE.

## Structure
- Shared package header (Mips/HiLo): func-code constants for the eight instructions, FSM state encodings, and an isHiLoOp predicate macro over OpFunc_T. The OpFunc_T and Source_* definitions are reused from the existing OpFunc headers.
- The controller holds the FSM, iteration counter, sign flags, and stall logic.
- One natural sub-module, mips_hilo_muldiv_datapath, holds the accumulator/remainder shift registers, the shared WIDTH+1-bit adder/subtractor, and the FIXUP negators. It is driven by step/load/fixup strobes from the controller.

## Test plan
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high for 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- MULT rs=-7 (0xFFFFFFF9) rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. An MFLO issued the cycle after acceptance holds stall=1 for 33 cycles, then reads 0xFFFFFFEB.
- DIV rs=-7 rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU rs=100 rt=7 -> lo=14, hi=2.
- DIV rt=0, rs=0x12345678 -> after 2 cycles lo=0xFFFFFFFF, hi=0x12345678; busy high for exactly 1 cycle.
- MTHI 0xDEAD then MTLO 0xBEEF back-to-back in IDLE -> hi=0xDEAD, lo=0xBEEF with no stalls. An ADD (Source_Op) issued during a MULT -> stall=0.
- Assert reset at cycle 10 of a MULT -> next cycle busy=0, hi=lo=0, stall=0. A following MULTU 3*5 gives lo=15.
